cozy_fetch_sequencer: RTL and testbench

//  Program-counter and instruction-fetch stage of the cozy CPU.

---
 rtl/cozy_fetch_sequencer.sv | 56 +++++
 tb/tb_cozy_fetch_sequencer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/cozy_fetch_sequencer.sv
// cozy_fetch_sequencer: PC and instruction-fetch stage, fetches one word per insn and selects next PC on retire
module cozy_fetch_sequencer #(
   parameter int                    ADDR_WIDTH = 16,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
   parameter logic [3:0]            BRANCH_OP  = 4'hE
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_req,
   input  logic                  mem_ack,
   input  logic [15:0]           mem_rdata,
   output logic [15:0]           insn,
   output logic                  insn_valid,
   output logic [ADDR_WIDTH-1:0] pc,
   input  logic                  cond_true,
   input  logic                  exec_done,
   input  logic                  jump_en,
   input  logic [ADDR_WIDTH-1:0] jump_target,
   output logic                  branch_taken
);
   typedef enum logic {S_FETCH, S_EXEC} state_t;
   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d, seq_pc, br_pc;
   logic [15:0]           insn_q, insn_d;
   logic                  br_q, br_d, retire, is_br;
   always_comb begin
      retire  = (state_q == S_EXEC) && exec_done;
      is_br   = (insn_q[15:12] == BRANCH_OP) && cond_true;
      seq_pc  = pc_q + ADDR_WIDTH'(1);
      br_pc   = seq_pc + {{(ADDR_WIDTH-9){insn_q[8]}}, insn_q[8:0]};
      pc_d    = retire ? (is_br ? br_pc : jump_en ? jump_target : seq_pc) : pc_q;
      br_d    = retire && (is_br || jump_en);
      insn_d  = (state_q == S_FETCH && mem_ack) ? mem_rdata : insn_q;
      state_d = (state_q == S_FETCH) ? (mem_ack ? S_EXEC : S_FETCH) : (exec_done ? S_FETCH : S_EXEC);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
         pc_q    <= RESET_PC;
         insn_q  <= 16'h0000;
         br_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         insn_q  <= insn_d;
         br_q    <= br_d;
      end
   end
   assign mem_req      = (state_q == S_FETCH) && !rst;
   assign mem_addr     = pc_q;
   assign pc           = pc_q;
   assign insn         = insn_q;
   assign insn_valid   = (state_q == S_EXEC);
   assign branch_taken = br_q;
endmodule

// File: tb/tb_cozy_fetch_sequencer.sv
// tb_cozy_fetch_sequencer: drives fetch/retire traffic and checks PC flow against an instruction-level model
module tb_cozy_fetch_sequencer;
   logic        clk = 0, rst = 1;
   logic [15:0] mem_addr, mem_rdata = 0, insn, pc, jump_target = 0;
   logic        mem_req, mem_ack = 0, insn_valid, cond_true = 0, exec_done = 0, jump_en = 0, branch_taken;
   int          errs = 0, checks = 0;
   logic [15:0] exp_pc = 0;
   cozy_fetch_sequencer dut (
      .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_req(mem_req), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata), .insn(insn), .insn_valid(insn_valid), .pc(pc),
      .cond_true(cond_true), .exec_done(exec_done), .jump_en(jump_en),
      .jump_target(jump_target), .branch_taken(branch_taken)
   );
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   function automatic logic [15:0] next_pc(input logic [15:0] p, input logic [15:0] w,
                                           input bit c, input bit j, input logic [15:0] t);
      int off;
      off = w[8] ? int'(w[8:0]) - 512 : int'(w[8:0]);
      if (w[15:12] == 4'hE && c) return 16'((int'(p) + 1 + off) % 65536);
      if (j) return t;
      return 16'((int'(p) + 1) % 65536);
   endfunction
   task automatic run_insn(input logic [15:0] w, input int fw, input int ew,
                           input bit c, input bit j, input logic [15:0] t);
      logic [15:0] tgt;
      bit          redir;
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== exp_pc) begin
         errs++; $display("FAIL fetch_start req=%b addr=%h want req=1 addr=%h", mem_req, mem_addr, exp_pc);
      end
      for (int i = 0; i < fw; i++) begin
         exec_done = 1'($urandom); jump_en = 1'($urandom);
         tick();
         checks++;
         if (mem_req !== 1'b1 || mem_addr !== exp_pc || insn_valid !== 1'b0) begin
            errs++; $display("FAIL fetch_hold req=%b addr=%h valid=%b want 1 %h 0", mem_req, mem_addr, insn_valid, exp_pc);
         end
      end
      exec_done = 0; jump_en = 0;
      mem_ack = 1; mem_rdata = w;
      tick();
      mem_ack = 0; mem_rdata = 16'($urandom);
      checks++;
      if (insn_valid !== 1'b1 || insn !== w || mem_req !== 1'b0 || branch_taken !== 1'b0) begin
         errs++; $display("FAIL load valid=%b insn=%h req=%b bt=%b want 1 %h 0 0", insn_valid, insn, mem_req, branch_taken, w);
      end
      for (int i = 0; i < ew; i++) begin
         mem_ack = 1'($urandom);
         tick();
         checks++;
         if (insn_valid !== 1'b1 || insn !== w || mem_req !== 1'b0) begin
            errs++; $display("FAIL exec_hold valid=%b insn=%h req=%b want 1 %h 0", insn_valid, insn, mem_req, w);
         end
      end
      mem_ack = 0;
      exec_done = 1; cond_true = c; jump_en = j; jump_target = t;
      tgt = next_pc(exp_pc, w, c, j, t);
      redir = (w[15:12] == 4'hE && c) || j;
      tick();
      exec_done = 0; cond_true = 0; jump_en = 0; jump_target = 16'($urandom);
      checks++;
      if (branch_taken !== redir || insn_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== tgt || pc !== tgt) begin
         errs++; $display("FAIL retire bt=%b valid=%b req=%b addr=%h pc=%h want %b 0 1 %h", branch_taken, insn_valid, mem_req, mem_addr, pc, redir, tgt);
      end
      exp_pc = tgt;
   endtask
   task automatic test_reset();
      rst = 1; mem_ack = 1; mem_rdata = 16'hDEAD; exec_done = 1; jump_en = 1;
      repeat (3) tick();
      checks++;
      if (mem_req !== 1'b0 || insn !== 16'h0 || insn_valid !== 1'b0 || branch_taken !== 1'b0 || pc !== 16'h0) begin
         errs++; $display("FAIL reset req=%b insn=%h valid=%b bt=%b pc=%h want 0 0000 0 0 0000", mem_req, insn, insn_valid, branch_taken, pc);
      end
      mem_ack = 0; exec_done = 0; jump_en = 0; rst = 0;
      #1;
      exp_pc = 0;
   endtask
   task automatic test_first_fetch();
      run_insn(16'h1234, 3, 0, 0, 0, 0);
   endtask
   task automatic test_sequential();
      for (int i = 0; i < 3; i++) run_insn(16'h2000 + 16'(i), 0, 0, 1'($urandom), 0, 0);
   endtask
   task automatic test_branch();
      run_insn(16'h1000, 0, 0, 0, 1, 16'h0010);
      run_insn(16'hE003, 1, 0, 1, 0, 0);
      run_insn(16'h1000, 0, 0, 0, 1, 16'h0010);
      run_insn(16'hE003, 0, 1, 0, 0, 0);
   endtask
   task automatic test_wrap();
      run_insn(16'h1000, 0, 0, 0, 1, 16'h0005);
      run_insn(16'hE1FF, 0, 0, 1, 0, 0);
      run_insn(16'h1000, 0, 0, 0, 1, 16'hFFFE);
      run_insn(16'hE005, 0, 0, 1, 0, 0);
   endtask
   task automatic test_priority();
      run_insn(16'hE003, 0, 0, 1, 1, 16'h0200);
      run_insn(16'h3000, 0, 0, 1, 1, 16'h0200);
   endtask
   task automatic test_random();
      logic [15:0] w;
      for (int n = 0; n < 40; n++) begin
         w = 16'($urandom);
         if ($urandom_range(1, 0) == 1) w[15:12] = 4'hE;
         run_insn(w, $urandom_range(3, 0), $urandom_range(3, 0), 1'($urandom), 1'($urandom), 16'($urandom));
      end
   endtask
   task automatic test_reset_mid();
      rst = 1; mem_ack = 1; mem_rdata = 16'hBEEF;
      tick();
      mem_ack = 0;
      checks++;
      if (insn !== 16'h0 || insn_valid !== 1'b0 || mem_req !== 1'b0) begin
         errs++; $display("FAIL rst_fetch insn=%h valid=%b req=%b want 0000 0 0", insn, insn_valid, mem_req);
      end
      rst = 0;
      #1;
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 16'h0) begin
         errs++; $display("FAIL rst_restart req=%b addr=%h want 1 0000", mem_req, mem_addr);
      end
      exp_pc = 0;
      run_insn(16'h1000, 0, 0, 0, 1, 16'h0040);
      mem_ack = 1; mem_rdata = 16'h4321;
      tick();
      mem_ack = 0; rst = 1; exec_done = 1; jump_en = 1; jump_target = 16'h0077;
      tick();
      exec_done = 0; jump_en = 0; rst = 0;
      #1;
      checks++;
      if (branch_taken !== 1'b0 || insn !== 16'h0 || insn_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 16'h0) begin
         errs++; $display("FAIL rst_exec bt=%b insn=%h valid=%b req=%b addr=%h want 0 0000 0 1 0000", branch_taken, insn, insn_valid, mem_req, mem_addr);
      end
      exp_pc = 0;
      run_insn(16'h1111, 1, 1, 0, 0, 0);
   endtask
   initial begin
      test_reset();
      test_first_fetch();
      test_sequential();
      test_branch();
      test_wrap();
      test_priority();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
